// File: rtl/level_debouncer.sv
// ============================================================================
// level_debouncer : qualifies a synchronized level over STABLE_CYCLES samples
//                   with rise/fall/glitch pulses; optional rise-event counter
//                   built when LEVEL_DEBOUNCER_EVENT_CNT_EN is defined.
// Revision 1.0
// ============================================================================
`default_nettype none

module level_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  input  logic                 levelIn,
  input  logic                 clrCntIn,
  output logic                 levelOut,
  output logic                 risePulseOut,
  output logic                 fallPulseOut,
  output logic                 glitchPulseOut,
  output logic [CNT_WIDTH-1:0] eventCntOut
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 65535) begin : g_bad_stable_cycles
    $fatal(1, "level_debouncer: STABLE_CYCLES out of range 1..65535");
  end
  if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_cnt_width
    $fatal(1, "level_debouncer: CNT_WIDTH out of range 1..32");
  end

  localparam int QCW = $clog2(STABLE_CYCLES + 1);
  localparam logic [QCW-1:0] STABLE_Q = QCW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_STABLE_LOW  = 2'd0,
    ST_QUAL_HIGH   = 2'd1,
    ST_STABLE_HIGH = 2'd2,
    ST_QUAL_LOW    = 2'd3
  } state_t;

  state_t         state_q,  state_d;
  logic [QCW-1:0] count_q,  count_d;
  logic           level_q,  level_d;
  logic           rise_q,   rise_d;
  logic           fall_q,   fall_d;
  logic           glitch_q, glitch_d;
  logic [QCW-1:0] count_inc;
  logic           accept_rise;

  assign count_inc = count_q + QCW'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    level_d     = level_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    glitch_d    = 1'b0;
    accept_rise = 1'b0;
    case (state_q)
      ST_STABLE_LOW: begin
        if (levelIn) begin
          // A single-sample qualification accepts on the first new sample.
          if (STABLE_CYCLES == 1) begin
            state_d     = ST_STABLE_HIGH;
            level_d     = 1'b1;
            rise_d      = 1'b1;
            accept_rise = 1'b1;
            count_d     = '0;
          end else begin
            state_d = ST_QUAL_HIGH;
            count_d = QCW'(1);
          end
        end
      end
      ST_QUAL_HIGH: begin
        if (levelIn) begin
          if (count_inc == STABLE_Q) begin
            state_d     = ST_STABLE_HIGH;
            level_d     = 1'b1;
            rise_d      = 1'b1;
            accept_rise = 1'b1;
            count_d     = '0;
          end else begin
            count_d = count_inc;
          end
        end else begin
          state_d  = ST_STABLE_LOW;
          count_d  = '0;
          glitch_d = 1'b1;
        end
      end
      ST_STABLE_HIGH: begin
        if (!levelIn) begin
          if (STABLE_CYCLES == 1) begin
            state_d = ST_STABLE_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
            count_d = '0;
          end else begin
            state_d = ST_QUAL_LOW;
            count_d = QCW'(1);
          end
        end
      end
      ST_QUAL_LOW: begin
        if (!levelIn) begin
          if (count_inc == STABLE_Q) begin
            state_d = ST_STABLE_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
            count_d = '0;
          end else begin
            count_d = count_inc;
          end
        end else begin
          state_d  = ST_STABLE_HIGH;
          count_d  = '0;
          glitch_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_STABLE_LOW;
        count_d = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      state_q  <= ST_STABLE_LOW;
      count_q  <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign levelOut       = level_q;
  assign risePulseOut   = rise_q;
  assign fallPulseOut   = fall_q;
  assign glitchPulseOut = glitch_q;

`ifdef LEVEL_DEBOUNCER_EVENT_CNT_EN
  logic [CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;

  // A clear coinciding with an accepted rise leaves that rise counted.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (clrCntIn) begin
      evt_cnt_d = accept_rise ? CNT_WIDTH'(1) : '0;
    end else if (accept_rise && (evt_cnt_q != {CNT_WIDTH{1'b1}})) begin
      evt_cnt_d = evt_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clkIn) begin
    if (!rstNIn) begin
      evt_cnt_q <= '0;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign eventCntOut = evt_cnt_q;
`else
  logic [1:0] unused_cnt_inputs;
  assign unused_cnt_inputs = {clrCntIn, accept_rise};
  assign eventCntOut       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_level_debouncer.sv
// ============================================================================
// tb_level_debouncer : randomized + directed scoreboard bench for level_debouncer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_level_debouncer;

  localparam int S  = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic          lvl;
    logic          rise;
    logic          fall;
    logic          glitch;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          level_in;
  logic          clr_in;
  logic          level_out;
  logic          rise_out;
  logic          fall_out;
  logic          glitch_out;
  logic [CW-1:0] cnt_out;

  always #5 clk = ~clk;

  level_debouncer #(
    .STABLE_CYCLES(S),
    .CNT_WIDTH    (CW)
  ) dut (
    .clkIn         (clk),
    .rstNIn        (rst_n),
    .levelIn       (level_in),
    .clrCntIn      (clr_in),
    .levelOut      (level_out),
    .risePulseOut  (rise_out),
    .fallPulseOut  (fall_out),
    .glitchPulseOut(glitch_out),
    .eventCntOut   (cnt_out)
  );

  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  // Reference model: accepted level plus the length of the current run of
  // samples disagreeing with it.
  bit m_level = 1'b0;
  int m_run   = 0;
  int m_cnt   = 0;

  task automatic step(input bit lv, input bit clr, input bit rn);
    exp_t e;
    bit   ev_rise = 1'b0;
    bit   ev_fall = 1'b0;
    bit   ev_gl   = 1'b0;
    @(negedge clk);
    level_in = lv;
    clr_in   = clr;
    rst_n    = rn;
    if (!rn) begin
      m_level = 1'b0;
      m_run   = 0;
      m_cnt   = 0;
    end else begin
      if (lv != m_level) begin
        m_run++;
        if (m_run == S) begin
          ev_rise = lv;
          ev_fall = !lv;
          m_level = lv;
          m_run   = 0;
        end
      end else begin
        ev_gl = (m_run > 0);
        m_run = 0;
      end
      if (clr)
        m_cnt = ev_rise ? 1 : 0;
      else if (ev_rise && m_cnt < (1 << CW) - 1)
        m_cnt++;
    end
    e.lvl    = m_level;
    e.rise   = ev_rise;
    e.fall   = ev_fall;
    e.glitch = ev_gl;
`ifdef LEVEL_DEBOUNCER_EVENT_CNT_EN
    e.cnt    = CW'(m_cnt);
`else
    e.cnt    = '0;
`endif
    sb_q.push_back(e);
  endtask

  task automatic hold(input bit lv, input int n);
    for (int i = 0; i < n; i++) step(lv, 1'b0, 1'b1);
  endtask

  // Monitor: one output word per clock, compared against the queue head.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb_q.size() > 0) begin
        e        = sb_q.pop_front();
        g.lvl    = level_out;
        g.rise   = rise_out;
        g.fall   = fall_out;
        g.glitch = glitch_out;
        g.cnt    = cnt_out;
        checks++;
        if (g === e) passed++;
        else $display("FAIL outputs cyc%0d: got lvl=%b rise=%b fall=%b glitch=%b cnt=%0d, expected lvl=%b rise=%b fall=%b glitch=%b cnt=%0d",
                      cyc, g.lvl, g.rise, g.fall, g.glitch, g.cnt,
                      e.lvl, e.rise, e.fall, e.glitch, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    level_in = 1'b0;
    clr_in   = 1'b0;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // Clean rise and fall, full latency.
    hold(1'b1, 8);
    hold(1'b0, 8);
    // Aborted qualification: three highs then low.
    hold(1'b1, 3);
    hold(1'b0, 5);
    // Five clean rising edges exercise counter saturation.
    for (int k = 0; k < 5; k++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
    // Clear alone, two rises, then clear on the accepting edge.
    step(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end
    hold(1'b1, 3);
    step(1'b1, 1'b1, 1'b1);
    hold(1'b1, 2);
    hold(1'b0, 6);
    // Reset during qualification with the input held high.
    hold(1'b1, 2);
    step(1'b1, 1'b0, 1'b0);
    hold(1'b1, 6);
    // Alternating input in both stable levels.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
    end
    hold(1'b0, 6);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
    end
    // Randomized traffic.
    begin
      bit cur = 1'b0;
      for (int k = 0; k < 800; k++) begin
        if ($urandom_range(0, 4) == 0) cur = !cur;
        step(cur, ($urandom_range(0, 31) == 0), ($urandom_range(0, 199) != 0));
      end
    end
    hold(1'b0, 6);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
